keypad_encoder: RTL

KEYPAD_ENCODER -- requirements
Module: keypad_encoder

---
 rtl/keypad_pkg.sv | 85 ++++++++
 rtl/keypad_debounce.sv | 36 +++
 rtl/keypad_encoder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 matrix keypad encoder.
//   state_t     : controller states (SCAN, DEBOUNCE, LATCH, STROBE, WAIT_RELEASE)
//   KEY_*       : 4-bit key codes; KEY_CMD (0xF, the '#' key) is the
//                 configuration-entry command
//   COLS_RESET  : column drive pattern after reset (column 0 driven low)
//   key_lookup  : row/column index -> key code
//   single_low  : true when exactly one bit of an active-low vector is low
//   low_index   : index of the lowest low bit of an active-low vector
// -----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [2:0] {
        SCAN         = 3'd0,
        DEBOUNCE     = 3'd1,
        LATCH        = 3'd2,
        STROBE       = 3'd3,
        WAIT_RELEASE = 3'd4
    } state_t;

    localparam logic [3:0] KEY_0    = 4'h0;
    localparam logic [3:0] KEY_1    = 4'h1;
    localparam logic [3:0] KEY_2    = 4'h2;
    localparam logic [3:0] KEY_3    = 4'h3;
    localparam logic [3:0] KEY_4    = 4'h4;
    localparam logic [3:0] KEY_5    = 4'h5;
    localparam logic [3:0] KEY_6    = 4'h6;
    localparam logic [3:0] KEY_7    = 4'h7;
    localparam logic [3:0] KEY_8    = 4'h8;
    localparam logic [3:0] KEY_9    = 4'h9;
    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_B    = 4'hB;
    localparam logic [3:0] KEY_C    = 4'hC;
    localparam logic [3:0] KEY_D    = 4'hD;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;
    localparam logic [3:0] KEY_CMD  = 4'hF;

    localparam logic [3:0] COLS_RESET = 4'b1110;

    // Layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
    function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        code = KEY_0;
        case ({r, c})
            4'b00_00: code = KEY_1;
            4'b00_01: code = KEY_2;
            4'b00_10: code = KEY_3;
            4'b00_11: code = KEY_A;
            4'b01_00: code = KEY_4;
            4'b01_01: code = KEY_5;
            4'b01_10: code = KEY_6;
            4'b01_11: code = KEY_B;
            4'b10_00: code = KEY_7;
            4'b10_01: code = KEY_8;
            4'b10_10: code = KEY_9;
            4'b10_11: code = KEY_C;
            4'b11_00: code = KEY_STAR;
            4'b11_01: code = KEY_0;
            4'b11_10: code = KEY_HASH;
            default:  code = KEY_D;
        endcase
        return code;
    endfunction

    function automatic logic single_low(input logic [3:0] v);
        logic [2:0] n;
        n = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            n = n + {2'b00, ~v[i]};
        end
        return (n == 3'd1);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = '0;
        for (int i = 3; i >= 0; i--) begin
            if (!v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// -----------------------------------------------------------------------------
// keypad_debounce
// Consecutive-cycle stability counter. o_done is high on the CYCLES-th
// consecutive cycle in which i_match is high; any cycle with i_match low, or
// i_restart high, clears the count.
//   clock     : system clock (rising edge)
//   reset     : synchronous active-high reset
//   i_match   : the watched condition holds this cycle
//   i_restart : clear the count (owner is not in the checking state)
//   o_done    : stability reached this cycle
// -----------------------------------------------------------------------------
module keypad_debounce #(
    parameter int unsigned CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic i_match,
    input  logic i_restart,
    output logic o_done
);

    localparam int unsigned CW = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);

    logic [CW-1:0] r_count;

    assign o_done = i_match && !i_restart && (r_count == CW'(CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset || i_restart || !i_match || o_done) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/keypad_encoder.sv
// -----------------------------------------------------------------------------
// keypad_encoder
// 4x4 matrix keypad scanner / debouncer / encoder.
//   clock   : system clock (rising edge)
//   reset   : synchronous active-high reset
//   rows    : row lines, active-low, asynchronous (2-flop synchronized)
//   cols    : column drive, one-hot active-low
//   dataOut : code of the last accepted key
//   dav     : data-available strobe, high DAV_WIDTH cycles per key event
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-strobe a held key every
// REPEAT_CYCLES cycles spent in WAIT_RELEASE.
// -----------------------------------------------------------------------------
module keypad_encoder
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 50000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned DAV_WIDTH       = 4,
    parameter int unsigned REPEAT_CYCLES   = 25000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] dataOut,
    output logic       dav
);

    localparam int unsigned DW = (SCAN_DIV < 2)  ? 1 : $clog2(SCAN_DIV + 1);
    localparam int unsigned SW = (DAV_WIDTH < 2) ? 1 : $clog2(DAV_WIDTH + 1);

    state_t        r_state;
    logic [3:0]    r_sync1;
    logic [3:0]    r_rows_s;
    logic [3:0]    r_cols;
    logic [3:0]    r_pattern;
    logic [3:0]    r_dataOut;
    logic [DW-1:0] r_div;
    logic [SW-1:0] r_strb;

    logic w_slot_end;
    logic w_press_match;
    logic w_press_restart;
    logic w_press_done;
    logic w_rel_match;
    logic w_rel_restart;
    logic w_rel_done;

    assign w_slot_end      = (r_div == DW'(SCAN_DIV - 1));
    assign w_press_match   = (r_state == DEBOUNCE) && (r_rows_s == r_pattern);
    assign w_press_restart = (r_state != DEBOUNCE);
    assign w_rel_match     = (r_state == WAIT_RELEASE) && (r_rows_s == 4'hF);
    assign w_rel_restart   = (r_state != WAIT_RELEASE);

    keypad_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_press_db (
        .clock     (clock),
        .reset     (reset),
        .i_match   (w_press_match),
        .i_restart (w_press_restart),
        .o_done    (w_press_done)
    );

    keypad_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_release_db (
        .clock     (clock),
        .reset     (reset),
        .i_match   (w_rel_match),
        .i_restart (w_rel_restart),
        .o_done    (w_rel_done)
    );

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned RW = (REPEAT_CYCLES < 2) ? 1 : $clog2(REPEAT_CYCLES + 1);

    logic [RW-1:0] r_rep;
    logic          w_rep_held;
    logic          w_rep_done;

    assign w_rep_held = (r_state == WAIT_RELEASE) && (r_rows_s == r_pattern);
    assign w_rep_done = w_rep_held && (r_rep == RW'(REPEAT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset || !w_rep_held || w_rep_done) begin
            r_rep <= '0;
        end else begin
            r_rep <= r_rep + RW'(1);
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1  <= 4'hF;
            r_rows_s <= 4'hF;
        end else begin
            r_sync1  <= rows;
            r_rows_s <= r_sync1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= SCAN;
            r_cols    <= COLS_RESET;
            r_pattern <= 4'hF;
            r_dataOut <= KEY_0;
            r_div     <= '0;
            r_strb    <= '0;
        end else begin
            case (r_state)
                SCAN: begin
                    if (w_slot_end) begin
                        r_div <= '0;
                        if (single_low(r_rows_s)) begin
                            r_state   <= DEBOUNCE;
                            r_pattern <= r_rows_s;
                        end else begin
                            r_cols <= {r_cols[2:0], r_cols[3]};
                        end
                    end else begin
                        r_div <= r_div + DW'(1);
                    end
                end
                DEBOUNCE: begin
                    if (r_rows_s != r_pattern) begin
                        r_state <= SCAN;
                        r_div   <= '0;
                    end else if (w_press_done) begin
                        // Code is captured on entry to LATCH so dataOut is
                        // already settled for the whole LATCH cycle, one cycle
                        // ahead of dav.
                        r_state   <= LATCH;
                        r_dataOut <= key_lookup(low_index(r_pattern), low_index(r_cols));
                    end
                end
                LATCH: begin
                    r_state <= STROBE;
                    r_strb  <= '0;
                end
                STROBE: begin
                    if (r_strb == SW'(DAV_WIDTH - 1)) begin
                        r_state <= WAIT_RELEASE;
                        r_strb  <= '0;
                    end else begin
                        r_strb <= r_strb + SW'(1);
                    end
                end
                WAIT_RELEASE: begin
                    if (w_rel_done) begin
                        r_state <= SCAN;
                        r_div   <= '0;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else if (w_rep_done) begin
                        r_state <= STROBE;
                        r_strb  <= '0;
                    end
`endif
                end
                default: begin
                    r_state <= SCAN;
                    r_div   <= '0;
                end
            endcase
        end
    end

    assign cols    = r_cols;
    assign dataOut = r_dataOut;
    assign dav     = (r_state == STROBE);

endmodule
